// File: rtl/cpu7_exu_lsu.sv
// rtl/cpu7_exu_lsu.sv - single-outstanding load/store unit bridging the E stage to a req/addr_ok/data_ok memory port
`timescale 1ns/1ps

module cpu7_exu_lsu #(
    parameter int LSOC1K_LSU_CODE_BIT = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           ecl_lsu_valid_e,
    input  logic [LSOC1K_LSU_CODE_BIT-1:0] ecl_lsu_op_e,
    input  logic [31:0]                    ecl_lsu_base_e,
    input  logic [31:0]                    ecl_lsu_offset_e,
    input  logic [31:0]                    ecl_lsu_wdata_e,
    input  logic [4:0]                     ecl_lsu_rd_e,
    input  logic                           ecl_lsu_wen_e,
    output logic                           lsu_ecl_stall,
    output logic                           lsu_ecl_ale_e,
    output logic [31:0]                    lsu_ecl_rdata_m,
    output logic                           lsu_ecl_rdata_valid_m,
    output logic [4:0]                     lsu_ecl_rd_m,
    output logic                           lsu_ecl_wen_m,
    output logic                           data_req,
    output logic                           data_wr,
    output logic [1:0]                     data_size,
    output logic [31:0]                    data_addr,
    output logic [31:0]                    data_wdata,
    output logic [3:0]                     data_wstrb,
    input  logic                           data_addr_ok,
    input  logic                           data_data_ok,
    input  logic [31:0]                    data_rdata
);

    // LSU code layout: [3] store, [2] zero-extend, [1:0] size (0 byte, 1 half, 2 word)
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_size;
    logic        r_st;
    logic        r_uns;
    logic [4:0]  r_rd;
    logic        r_wen;
    logic [31:0] r_rdata;

    logic [31:0] w_addr;
    logic [1:0]  w_size;
    logic        w_st;
    logic        w_misalign;
    logic        w_in_idle;
    logic        w_accept;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_addr = ecl_lsu_base_e + ecl_lsu_offset_e;
    assign w_size = (ecl_lsu_op_e[1:0] == 2'd3) ? 2'd2 : ecl_lsu_op_e[1:0];
    assign w_st   = ecl_lsu_op_e[3];

    assign w_misalign = ((w_size == 2'd1) && w_addr[0]) ||
                        ((w_size == 2'd2) && (w_addr[1:0] != 2'b00));

    // Gating with resetn keeps the combinational handshake quiet while reset is held
    assign w_in_idle = resetn && (r_state == S_IDLE);
    assign w_accept  = w_in_idle && ecl_lsu_valid_e && !w_misalign;

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = ecl_lsu_wdata_e;
        case (w_size)
            2'd0: begin
                w_wstrb = 4'b0001 << w_addr[1:0];
                w_wdata = {4{ecl_lsu_wdata_e[7:0]}};
            end
            2'd1: begin
                w_wstrb = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{ecl_lsu_wdata_e[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = ecl_lsu_wdata_e;
            end
        endcase
        if (!w_st) begin
            w_wstrb = 4'b0000;
        end
    end

    always_comb begin
        w_byte = data_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_half = data_rdata[{r_addr[1], 4'b0000} +: 16];
        case (r_size)
            2'd0:    w_ext = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'd1:    w_ext = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_ext = data_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
            r_size  <= 2'd0;
            r_st    <= 1'b0;
            r_uns   <= 1'b0;
            r_rd    <= 5'd0;
            r_wen   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_wstrb <= w_wstrb;
                        r_size  <= w_size;
                        r_st    <= w_st;
                        r_uns   <= ecl_lsu_op_e[2];
                        r_rd    <= ecl_lsu_rd_e;
                        r_wen   <= ecl_lsu_wen_e;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (data_addr_ok) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        if (r_st) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_rdata <= w_ext;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign lsu_ecl_stall = resetn && ((r_state != S_IDLE) || w_accept);
    assign lsu_ecl_ale_e = w_in_idle && ecl_lsu_valid_e && w_misalign;

    assign data_req   = (r_state == S_REQ);
    assign data_wr    = data_req && r_st;
    assign data_size  = data_req ? r_size  : 2'd0;
    assign data_addr  = data_req ? r_addr  : 32'd0;
    assign data_wdata = data_req ? r_wdata : 32'd0;
    assign data_wstrb = data_req ? r_wstrb : 4'd0;

    assign lsu_ecl_rdata_valid_m = (r_state == S_RESP);
    assign lsu_ecl_rdata_m       = lsu_ecl_rdata_valid_m ? r_rdata : 32'd0;
    assign lsu_ecl_rd_m          = lsu_ecl_rdata_valid_m ? r_rd    : 5'd0;
    assign lsu_ecl_wen_m         = lsu_ecl_rdata_valid_m && r_wen;

endmodule

// File: tb/tb_cpu7_exu_lsu.sv
// tb/tb_cpu7_exu_lsu.sv - scoreboard bench for cpu7_exu_lsu with a randomized memory responder
`timescale 1ns/1ps

module tb_cpu7_exu_lsu;

    localparam logic [3:0] OP_LDB  = 4'h0;
    localparam logic [3:0] OP_LDH  = 4'h1;
    localparam logic [3:0] OP_LDW  = 4'h2;
    localparam logic [3:0] OP_LDBU = 4'h4;
    localparam logic [3:0] OP_LDHU = 4'h5;
    localparam logic [3:0] OP_STB  = 4'h8;
    localparam logic [3:0] OP_STH  = 4'h9;
    localparam logic [3:0] OP_STW  = 4'hA;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        int          cyc;
    } resp_t;

    typedef struct {
        int          aok;
        int          dok;
        logic [31:0] rdata;
    } mem_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ecl_lsu_valid_e;
    logic [3:0]  ecl_lsu_op_e;
    logic [31:0] ecl_lsu_base_e;
    logic [31:0] ecl_lsu_offset_e;
    logic [31:0] ecl_lsu_wdata_e;
    logic [4:0]  ecl_lsu_rd_e;
    logic        ecl_lsu_wen_e;
    logic        lsu_ecl_stall;
    logic        lsu_ecl_ale_e;
    logic [31:0] lsu_ecl_rdata_m;
    logic        lsu_ecl_rdata_valid_m;
    logic [4:0]  lsu_ecl_rd_m;
    logic        lsu_ecl_wen_m;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    cpu7_exu_lsu #(.LSOC1K_LSU_CODE_BIT(4)) dut (
        .clk                   (clk),
        .resetn                (resetn),
        .ecl_lsu_valid_e       (ecl_lsu_valid_e),
        .ecl_lsu_op_e          (ecl_lsu_op_e),
        .ecl_lsu_base_e        (ecl_lsu_base_e),
        .ecl_lsu_offset_e      (ecl_lsu_offset_e),
        .ecl_lsu_wdata_e       (ecl_lsu_wdata_e),
        .ecl_lsu_rd_e          (ecl_lsu_rd_e),
        .ecl_lsu_wen_e         (ecl_lsu_wen_e),
        .lsu_ecl_stall         (lsu_ecl_stall),
        .lsu_ecl_ale_e         (lsu_ecl_ale_e),
        .lsu_ecl_rdata_m       (lsu_ecl_rdata_m),
        .lsu_ecl_rdata_valid_m (lsu_ecl_rdata_valid_m),
        .lsu_ecl_rd_m          (lsu_ecl_rd_m),
        .lsu_ecl_wen_m         (lsu_ecl_wen_m),
        .data_req              (data_req),
        .data_wr               (data_wr),
        .data_size             (data_size),
        .data_addr             (data_addr),
        .data_wdata            (data_wdata),
        .data_wstrb            (data_wstrb),
        .data_addr_ok          (data_addr_ok),
        .data_data_ok          (data_data_ok),
        .data_rdata            (data_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_checks = 0;
    int    n_pass   = 0;
    req_t  req_q[$];
    resp_t resp_q[$];
    mem_t  mem_q[$];
    int    ale_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: memory byte lanes as plain arithmetic on the little-endian word
    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                               input logic [31:0] word);
        int     nb;
        longint m;
        longint v;
        nb = 1 << op[1:0];
        if (nb == 4) return word;
        m = longint'(1) << (8 * nb);
        v = (longint'(word) >> (8 * int'(addr[1:0]))) % m;
        if (!op[2] && v >= m / 2) v = v - m;
        return v[31:0];
    endfunction

    function automatic req_t model_req(input logic [3:0] op, input logic [31:0] addr,
                                       input logic [31:0] wd);
        req_t r;
        int   nb;
        nb = 1 << op[1:0];
        r.addr  = addr;
        r.size  = op[1:0];
        r.wr    = op[3];
        r.wstrb = op[3] ? 4'((((1 << nb) - 1) << addr[1:0])) : 4'd0;
        if (nb == 1)      r.wdata = (wd & 32'hFF) * 32'h0101_0101;
        else if (nb == 2) r.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
        else              r.wdata = wd;
        return r;
    endfunction

    task automatic wait_idle();
        int k;
        k = 0;
        @(posedge clk); #1;
        while (lsu_ecl_stall && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) chk("stall_timeout", {31'd0, lsu_ecl_stall}, 32'd0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] wd, input logic [4:0] rd, input logic wen,
                         input logic [31:0] rdata, input int aok, input int dok, input bit want_resp);
        logic [31:0] addr;
        resp_t       rs;
        mem_t        mm;
        wait_idle();
        addr = base + off;
        ecl_lsu_valid_e  = 1'b1;
        ecl_lsu_op_e     = op;
        ecl_lsu_base_e   = base;
        ecl_lsu_offset_e = off;
        ecl_lsu_wdata_e  = wd;
        ecl_lsu_rd_e     = rd;
        ecl_lsu_wen_e    = wen;
        if ((addr % (32'd1 << op[1:0])) != 0) begin
            ale_q.push_back(cyc);
        end else begin
            req_q.push_back(model_req(op, addr, wd));
            mm.aok = aok; mm.dok = dok; mm.rdata = rdata;
            mem_q.push_back(mm);
            if (!op[3] && want_resp) begin
                rs.data = model_load(op, addr, rdata);
                rs.rd   = rd;
                rs.wen  = wen;
                rs.cyc  = cyc + 3 + aok + dok;
                resp_q.push_back(rs);
            end
        end
        @(posedge clk); #1;
        ecl_lsu_valid_e = 1'b0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_ctl"}, {15'd0, lsu_ecl_stall, lsu_ecl_ale_e, lsu_ecl_rdata_valid_m, lsu_ecl_rd_m,
                             lsu_ecl_wen_m, data_req, data_wr, data_size, data_wstrb}, 32'd0);
        chk({name, "_rdata"}, lsu_ecl_rdata_m, 32'd0);
        chk({name, "_addr"}, data_addr | data_wdata, 32'd0);
    endtask

    // Memory responder: stray data_ok outside WAIT must be ignored by the DUT
    initial begin
        mem_t m;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
        forever begin
            @(posedge clk); #2;
            if (data_req && mem_q.size() > 0) begin
                m = mem_q.pop_front();
                repeat (m.aok) begin
                    data_data_ok = 1'($urandom_range(0, 1));
                    @(posedge clk); #2;
                end
                data_addr_ok = 1'b1;
                data_data_ok = 1'($urandom_range(0, 1));
                @(posedge clk); #2;
                data_addr_ok = 1'b0;
                data_data_ok = 1'b0;
                repeat (m.dok) begin @(posedge clk); #2; end
                data_data_ok = 1'b1;
                data_rdata   = m.rdata;
                @(posedge clk); #2;
                data_data_ok = 1'b0;
                data_rdata   = $urandom;
            end else begin
                data_data_ok = 1'($urandom_range(0, 1));
                data_rdata   = $urandom;
            end
        end
    end

    // Monitor: compares DUT output events against the scoreboard queues
    initial begin
        req_t  r;
        resp_t s;
        int    a;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (data_req) begin
                    if (req_q.size() == 0) begin
                        chk("unexpected_req", {31'd0, data_req}, 32'd0);
                    end else begin
                        r = req_q[0];
                        chk("req_addr", data_addr, r.addr);
                        chk("req_wr", {31'd0, data_wr}, {31'd0, r.wr});
                        chk("req_size", {30'd0, data_size}, {30'd0, r.size});
                        chk("req_wstrb", {28'd0, data_wstrb}, {28'd0, r.wstrb});
                        if (r.wr) chk("req_wdata", data_wdata, r.wdata);
                        chk("req_stall", {31'd0, lsu_ecl_stall}, 32'd1);
                        if (data_addr_ok) void'(req_q.pop_front());
                    end
                end
                if (lsu_ecl_rdata_valid_m) begin
                    if (resp_q.size() == 0) begin
                        chk("unexpected_rvalid", {31'd0, lsu_ecl_rdata_valid_m}, 32'd0);
                    end else begin
                        s = resp_q.pop_front();
                        chk("rdata_m", lsu_ecl_rdata_m, s.data);
                        chk("rd_m", {27'd0, lsu_ecl_rd_m}, {27'd0, s.rd});
                        chk("wen_m", {31'd0, lsu_ecl_wen_m}, {31'd0, s.wen});
                        chk("resp_cycle", cyc, s.cyc);
                    end
                end
                if (lsu_ecl_ale_e) begin
                    if (ale_q.size() == 0) begin
                        chk("unexpected_ale", {31'd0, lsu_ecl_ale_e}, 32'd0);
                    end else begin
                        a = ale_q.pop_front();
                        chk("ale_cycle", cyc, a);
                        chk("ale_stall", {31'd0, lsu_ecl_stall}, 32'd0);
                        chk("ale_req", {31'd0, data_req}, 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ops[8] = '{OP_LDB, OP_LDH, OP_LDW, OP_LDBU, OP_LDHU, OP_STB, OP_STH, OP_STW};
        logic [3:0]  op;
        logic [31:0] base;
        logic [31:0] off;
        resetn           = 1'b0;
        ecl_lsu_valid_e  = 1'b1;
        ecl_lsu_op_e     = OP_LDW;
        ecl_lsu_base_e   = 32'h100;
        ecl_lsu_offset_e = 32'h0;
        ecl_lsu_wdata_e  = 32'h0;
        ecl_lsu_rd_e     = 5'd3;
        ecl_lsu_wen_e    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset_aligned");
        ecl_lsu_offset_e = 32'h2;
        #1;
        chk_quiet("reset_misaligned");
        ecl_lsu_valid_e = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        issue(OP_LDW, 32'h1000, 32'h4, 32'h0, 5'd9, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b1);
        issue(OP_LDB, 32'h2000, 32'h3, 32'h0, 5'd1, 1'b1, 32'h80FF_FFFF, 0, 0, 1'b1);
        issue(OP_LDBU, 32'h2000, 32'h3, 32'h0, 5'd2, 1'b0, 32'h80FF_FFFF, 0, 0, 1'b1);
        issue(OP_STH, 32'h3000, 32'h2, 32'h1234_ABCD, 5'd4, 1'b1, 32'h0, 0, 0, 1'b1);
        issue(OP_LDW, 32'h4000, 32'h1, 32'h0, 5'd5, 1'b1, 32'h0, 0, 0, 1'b1);

        // Slow memory while ECL presents another request that must not be taken
        issue(OP_LDH, 32'h6000, 32'h2, 32'h0, 5'd12, 1'b1, 32'hC3A5_1234, 3, 2, 1'b1);
        ecl_lsu_valid_e  = 1'b1;
        ecl_lsu_op_e     = OP_STW;
        ecl_lsu_base_e   = 32'h7000;
        ecl_lsu_offset_e = 32'h0;
        ecl_lsu_rd_e     = 5'd30;
        for (int i = 0; i < 5; i++) begin
            chk("busy_stall", {31'd0, lsu_ecl_stall}, 32'd1);
            @(posedge clk); #1;
        end
        ecl_lsu_valid_e = 1'b0;

        issue(OP_LDW, 32'hFFFF_FFFC, 32'h8, 32'h0, 5'd6, 1'b1, 32'h0BAD_F00D, 0, 1, 1'b1);

        // Abandon a load in WAIT; its late data_ok must produce nothing
        issue(OP_LDW, 32'h5000, 32'h10, 32'h0, 5'd7, 1'b1, 32'h1111_2222, 0, 4, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk_quiet("reset_in_wait");
        @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk_quiet("after_abandon");

        for (int n = 0; n < 60; n++) begin
            op   = ops[$urandom_range(0, 7)];
            base = $urandom;
            off  = $urandom;
            if ($urandom_range(0, 3) != 0) off = off - ((base + off) % (32'd1 << op[1:0]));
            issue(op, base, off, $urandom, 5'($urandom), 1'($urandom), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        end

        wait_idle();
        repeat (10) @(posedge clk);
        #1;
        chk("req_q_drained", req_q.size(), 32'd0);
        chk("resp_q_drained", resp_q.size(), 32'd0);
        chk("ale_q_drained", ale_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu7_exu_lsu.md
CPU7_EXU_LSU -- requirements
Module: cpu7_exu_lsu

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; GRLEN is 32 in this build.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1: clock
- resetn in 1: async active-low reset
- ecl_lsu_valid_e in 1: memory op presented in E
- ecl_lsu_op_e in LSOC1K_LSU_CODE_BIT: decoded.vh LSU code (LD.B/H/W/BU/HU, ST.B/H/W)
- ecl_lsu_base_e in 32: base
- ecl_lsu_offset_e in 32: offset
- ecl_lsu_wdata_e in 32: store data
- ecl_lsu_rd_e in 5: load target
- ecl_lsu_wen_e in 1: load writes rd
- lsu_ecl_stall out 1: ECL must hold E
- lsu_ecl_ale_e out 1: misaligned-address pulse
- lsu_ecl_rdata_m out 32: extended load data
- lsu_ecl_rdata_valid_m out 1: load-return pulse
- lsu_ecl_rd_m out 5: returned rd
- lsu_ecl_wen_m out 1: returned wen
- data_req out 1: memory request
- data_wr out 1: 1 = store
- data_size out 2: 0 byte, 1 half, 2 word
- data_addr out 32: byte address
- data_wdata out 32: lane-replicated store data
- data_wstrb out 4: byte strobes
- data_addr_ok in 1: request accepted
- data_data_ok in 1: read data ready / write done
- data_rdata in 32: read word

Function
REQ-003 addr SHALL be base + offset, truncated to 32 bits (wrap-around, no carry out).
REQ-004 FSM states SHALL be IDLE, REQ, WAIT and RESP; only IDLE accepts ecl_lsu_valid_e.
REQ-005 In IDLE with valid=1, the block SHALL check alignment: a half with addr[0]=1 or a word with addr[1:0]!=0 SHALL assert lsu_ecl_ale_e in that cycle. It SHALL issue no request and no return, and SHALL stay in IDLE.
REQ-006 In IDLE with valid=1 and the address aligned, the block SHALL latch addr, op, wdata, rd and wen, and SHALL go to REQ next cycle.
REQ-007 In REQ, data_req SHALL be 1 with stable latched fields; data_addr_ok=1 SHALL move to WAIT, otherwise the block SHALL remain in REQ.
REQ-008 In WAIT, data_req SHALL be 0; data_data_ok=1 SHALL capture data_rdata and move to RESP for a load, or to IDLE for a store. data_data_ok SHALL be ignored outside WAIT.
REQ-009 In RESP (one cycle), for a load: lsu_ecl_rdata_valid_m SHALL be 1, rdata_m SHALL carry the extended data, and rd_m/wen_m SHALL carry the latched values; the next state SHALL be IDLE.
REQ-010 Load extraction: the byte SHALL be taken at data_rdata[8*addr[1:0]+:8] and the half at data_rdata[16*addr[1]+:16]. LD.B and LD.H SHALL sign-extend; BU and HU SHALL zero-extend; W SHALL pass through unchanged.
REQ-011 Store strobes and data SHALL be:
- byte: wstrb = 1<<addr[1:0], wdata = {4{b}}
- half: wstrb = 0011 or 1100 by addr[1], wdata = {2{h}}
- word: wstrb = 1111
- loads: wstrb = 0000
REQ-012 lsu_ecl_stall SHALL be 1 when state!=IDLE, or in IDLE when an aligned valid request is being accepted; the ECL holding E until stall drops is the handshake.
REQ-013 lsu_ecl_rdata_valid_m, lsu_ecl_ale_e and data_req SHALL be 0 in every cycle not listed above.
REQ-014 Minimum load latency, accepted at T with addr_ok at T+1 and data_ok at T+2, SHALL be: rdata_valid_m at T+3 and next accept at T+4.

Reset
REQ-015 While resetn=0, the state SHALL be IDLE and all outputs SHALL be 0, with no stored request.
REQ-016 Reset asserted mid-transaction SHALL abandon it: no return SHALL follow, and a data_data_ok arriving after reset SHALL be ignored.

Verification
REQ-017 LD.W, base=0x1000, offset=0x4, addr_ok and data_ok immediate, rdata=0xDEADBEEF -> data_addr=0x1004 and size=2; rdata_valid_m 3 cycles after accept with rdata_m=0xDEADBEEF and rd/wen echoed.
REQ-018 LD.B vs LD.BU at addr 0x2003, rdata=0x80FF_FFFF -> LD.B returns 0xFFFFFF80 and LD.BU returns 0x00000080.
REQ-019 ST.H at addr 0x3002, wdata=0x1234ABCD -> wstrb=1100, wdata=0xABCDABCD and wr=1; no rdata_valid_m pulse.
REQ-020 LD.W at addr 0x4001 -> ale=1 for one cycle, data_req never asserted, stall=0.
REQ-021 addr_ok held 0 for 3 cycles, then data_ok delayed 2 cycles -> data_req and address stay stable; stall stays 1 throughout and a new valid is not accepted.
REQ-022 base=0xFFFFFFFC, offset=0x8 -> addr=0x00000004. Reset pulsed in WAIT, then data_ok -> no return and outputs 0.
